interleaver_block_ctrl: RTL and testbench

Sequencing controller for the combinational `coder_interleaver`.
- Collects one code block from a byte-wide valid/ready input stream into a block register.
- Drives the block and the `K_eq_6144` block-size select into the interleaver and waits a fixed settle time.
- Captures the permuted `cout` result and streams it out byte-wide with backpressure.
- Sits between the upstream framer and the turbo constituent encoders.

---
 rtl/turbo_pkg.sv | 29 ++
 rtl/ilv_byte_sel.sv | 25 ++
 rtl/interleaver_block_ctrl.sv | 178 +++++++++++++++++
 tb/tb_interleaver_block_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
// Shared constants and types for the turbo-encoder interleaver controller.
//   K_MAX / K_SHORT       : long and short code block sizes in bits
//   NBYTES_LONG / _SHORT  : the same sizes expressed in bytes
//   state_e               : block controller sequencing states
//   nbytes()              : byte count of a block for a given size select
// -----------------------------------------------------------------------------
package turbo_pkg;

   localparam int K_MAX        = 6144;
   localparam int K_SHORT      = 1056;
   localparam int NBYTES_LONG  = 768;
   localparam int NBYTES_SHORT = 132;
   localparam int IDX_W        = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      PERMUTE = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   // Number of bytes in a block given the K_eq_6144 select.
   function automatic logic [IDX_W-1:0] nbytes(input logic k_long);
      return k_long ? IDX_W'(NBYTES_LONG) : IDX_W'(NBYTES_SHORT);
   endfunction

endpackage

// File: rtl/ilv_byte_sel.sv
// -----------------------------------------------------------------------------
// ilv_byte_sel
// Byte-select multiplexer: returns byte idx_i (bits [8*idx+7:8*idx]) of a
// W-bit vector.
//   vec_i  in  W      source vector
//   idx_i  in  IDX_W  byte index, 0 = least significant byte
//   byte_o out 8      selected byte
// -----------------------------------------------------------------------------
module ilv_byte_sel #(
   parameter int W     = 6144,
   parameter int IDX_W = 10
) (
   input  logic [W-1:0]     vec_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [7:0]       byte_o
);

   localparam int NB = W / 8;

   logic [NB-1:0][7:0] bytes;

   assign bytes  = vec_i;
   assign byte_o = bytes[idx_i];

endmodule

// File: rtl/interleaver_block_ctrl.sv
// -----------------------------------------------------------------------------
// interleaver_block_ctrl
// Sequencing controller around the combinational coder_interleaver. Collects
// one code block byte-wise, presents it to the interleaver for PERM_LAT
// cycles, captures the permuted result and streams it out byte-wise.
//   clock, reset_n        system clock, synchronous active-low reset
//   in_data/valid/first   input byte stream; in_first marks byte 0 of a block
//   in_k6144              block size, sampled with the first byte
//   in_ready              controller accepts a byte this cycle
//   ilv_cin/ilv_k_eq_6144 block register and size select to the interleaver
//   ilv_cout              permuted block from the interleaver
//   out_data/valid/last   output byte stream, out_last on the final byte
//   out_ready             downstream backpressure
//   busy                  controller is not IDLE
//   err_pulse             one-cycle pulse on a protocol error
// -----------------------------------------------------------------------------
module interleaver_block_ctrl
   import turbo_pkg::*;
#(
   parameter int unsigned PERM_LAT = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             in_k6144,
   output logic             in_ready,
   output logic [K_MAX-1:0] ilv_cin,
   output logic             ilv_k_eq_6144,
   input  logic [K_MAX-1:0] ilv_cout,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             err_pulse
);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       cnt_q, cnt_d;
   logic [3:0]             settle_q, settle_d;
   logic [K_MAX-1:0]       cin_q, cin_d;
   logic [K_MAX-1:0]       oreg_q, oreg_d;
   logic                   k_q, k_d;
   logic                   err_q, err_d;

   logic                   in_xfer, out_xfer;
   logic [IDX_W-1:0]       nb, cnt_inc;
   logic                   wr_en, clr_cin, capture;
   logic [IDX_W-1:0]       wr_idx;
   logic [NBYTES_LONG-1:0] byte_we;

   // Handshake outputs come from registered state only, so out_valid has no
   // combinational dependence on out_ready.
   assign in_ready  = (state_q == IDLE) || (state_q == FILL);
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != IDLE);
   assign nb        = nbytes(k_q);
   assign cnt_inc   = cnt_q + IDX_W'(1);
   assign out_last  = out_valid && (cnt_q == nb - IDX_W'(1));
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   assign ilv_cin       = cin_q;
   assign ilv_k_eq_6144 = k_q;
   assign err_pulse     = err_q;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      k_d      = k_q;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = cnt_q;
      clr_cin  = 1'b0;
      capture  = 1'b0;

      unique case (state_q)
         IDLE, FILL: begin
            if (in_xfer) begin
               if (in_first) begin
                  // A first byte (re)starts a block; mid-fill it abandons the
                  // partial block and is flagged as an error.
                  err_d   = (state_q == FILL);
                  k_d     = in_k6144;
                  clr_cin = 1'b1;
                  wr_en   = 1'b1;
                  wr_idx  = '0;
                  cnt_d   = IDX_W'(1);
                  state_d = FILL;
               end else if (state_q == IDLE) begin
                  err_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  cnt_d = cnt_inc;
                  if (cnt_inc == nb) begin
                     settle_d = '0;
                     state_d  = PERMUTE;
                  end
               end
            end
         end
         PERMUTE: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == 4'(PERM_LAT - 1)) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_xfer) begin
               if (out_last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-byte write enable for the block register.
   always_comb begin
      byte_we = '0;
      if (wr_en) byte_we[wr_idx] = 1'b1;
   end

   // Clearing on a block start keeps the unused upper bits of a short block 0.
   always_comb begin
      cin_d = clr_cin ? '0 : cin_q;
      for (int b = 0; b < NBYTES_LONG; b++) begin
         if (byte_we[b]) cin_d[8*b +: 8] = in_data;
      end
   end

   assign oreg_d = capture ? ilv_cout : oreg_q;

   // NOTE: state uses non-blocking assignments so every register samples its
   // pre-edge value; the reset is synchronous, tested inside the clocked block.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         settle_q <= '0;
         k_q      <= 1'b0;
         err_q    <= 1'b0;
         // NOTE: the wide block and output registers are reset too, so after a
         // reset the interleaver and output port never see a stale block.
         cin_q    <= '0;
         oreg_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         k_q      <= k_d;
         err_q    <= err_d;
         cin_q    <= cin_d;
         oreg_q   <= oreg_d;
      end
   end

   ilv_byte_sel #(
      .W     (K_MAX),
      .IDX_W (IDX_W)
   ) u_out_sel (
      .vec_i  (oreg_q),
      .idx_i  (cnt_q),
      .byte_o (out_data)
   );

endmodule

// File: tb/tb_interleaver_block_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interleaver_block_ctrl
// Scoreboard bench: the driver feeds bytes into a block-level reference model
// that queues the expected output bytes; an independent monitor pops and
// compares on every output handshake. The interleaver is a stub that passes
// the block through, optionally inverted, so capture of cout is observable.
// -----------------------------------------------------------------------------
module tb_interleaver_block_ctrl;

   localparam int PERM_LAT = 2;
   localparam int KW       = 6144;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [7:0]    in_data;
   logic          in_valid, in_first, in_k6144, in_ready;
   logic [KW-1:0] ilv_cin, ilv_cout;
   logic          ilv_k_eq_6144;
   logic [7:0]    out_data;
   logic          out_valid, out_ready, out_last, busy, err_pulse;

   logic          stub_inv = 1'b0;

   always #5 clock = ~clock;

   assign ilv_cout = stub_inv ? ~ilv_cin : ilv_cin;

   interleaver_block_ctrl #(.PERM_LAT(PERM_LAT)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_first      (in_first),
      .in_k6144      (in_k6144),
      .in_ready      (in_ready),
      .ilv_cin       (ilv_cin),
      .ilv_k_eq_6144 (ilv_k_eq_6144),
      .ilv_cout      (ilv_cout),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .busy          (busy),
      .err_pulse     (err_pulse)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [8:0] exp_q[$];     // {last, data}
   logic [7:0] part[$];      // bytes of the block being collected
   logic       part_k = 1'b0;
   int         err_exp = 0;

   function automatic void model_accept(input logic [7:0] d, input logic f, input logic k);
      int n;
      if (f) begin
         if (part.size() != 0) err_exp++;
         part.delete();
         part.push_back(d);
         part_k = k;
      end else if (part.size() == 0) begin
         err_exp++;
      end else begin
         part.push_back(d);
      end
      n = (part_k ? 6144 : 1056) / 8;
      if (part.size() == n) begin
         for (int i = 0; i < n; i++)
            exp_q.push_back({i == n - 1, part[i] ^ (stub_inv ? 8'hFF : 8'h00)});
         part.delete();
      end
   endfunction

   // ---------------- cycle counter and output backpressure ----------------
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int out_mode = 0;  // 0: always ready, 1: toggle, 2: random
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- monitor ----------------
   int         err_seen = 0;
   int         pop_count = 0;
   int         last_xfer_cyc = 0;
   logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_err = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [8:0] exp_item;

   always @(negedge clock) begin
      if (!reset_n) begin
         prev_valid = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
         end
         if (out_valid && !prev_valid)
            check("first_out_latency", cyc - last_xfer_cyc, PERM_LAT + 1);
         if (err_pulse) begin
            err_seen++;
            check("err_pulse_width", prev_err, 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", out_valid && out_ready, 0);
            end else begin
               exp_item = exp_q.pop_front();
               check("out_byte", {out_last, out_data}, exp_item);
               pop_count++;
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_err   = err_pulse;
      end
   end

   // ---------------- driver ----------------
   logic gaps_en = 1'b0;

   // Entered and left at posedge+1.
   task automatic send_byte(input logic [7:0] d, input logic f, input logic k);
      int t;
      if (gaps_en && $urandom_range(0, 3) == 0) begin
         @(posedge clock);
         #1;
      end
      in_data  = d;
      in_first = f;
      in_k6144 = f ? k : 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      t = 0;
      @(negedge clock);
      while (!in_ready && t < 4000) begin
         t++;
         @(negedge clock);
      end
      if (t >= 4000) check("in_ready_timeout", in_ready, 1);
      model_accept(d, f, k);
      last_xfer_cyc = cyc;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_first = 1'($urandom_range(0, 1));
      in_k6144 = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
   endtask

   // pattern: 0 = i mod 256, 1 = 0xA5, other = random
   task automatic send_block(input logic k, input int pattern);
      int n;
      logic [7:0] d;
      n = (k ? 6144 : 1056) / 8;
      for (int i = 0; i < n; i++) begin
         case (pattern)
            0:       d = 8'(i);
            1:       d = 8'hA5;
            default: d = 8'($urandom);
         endcase
         send_byte(d, i == 0, k);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 20000) begin
         t++;
         @(negedge clock);
      end
      if (t >= 20000) check("drain_timeout", exp_q.size(), 0);
      repeat (2) @(negedge clock);
      check("err_count", err_seen, err_exp);
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_cin_zero"}, ilv_cin == '0, 1);
      check({tag, "_k"}, ilv_k_eq_6144, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_err"}, err_pulse, 0);
   endtask

   initial begin
      logic [1055:0] a5v;
      int base, t;

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_k6144 = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check_reset_state("reset");
      @(posedge clock);
      #1;

      // Long block, identity, counting pattern.
      stub_inv = 1'b0;
      send_block(1'b1, 0);
      wait_idle();

      // Short block of 0xA5: inspect the block register during PERMUTE.
      send_block(1'b0, 1);
      for (int i = 0; i < 132; i++) a5v[8*i +: 8] = 8'hA5;
      check("permute_cin_low", ilv_cin[1055:0] == a5v, 1);
      check("permute_cin_high_zero", ilv_cin[KW-1:1056] == '0, 1);
      check("permute_k", ilv_k_eq_6144, 0);
      check("permute_in_ready", in_ready, 0);
      check("permute_busy", busy, 1);
      wait_idle();

      // Backpressure with toggling out_ready and inverted cout.
      stub_inv = 1'b1;
      out_mode = 1;
      base = pop_count;
      send_block(1'b0, 2);
      wait_idle();
      check("bp_transfers", pop_count - base, 132);
      out_mode = 0;

      // in_first reasserted at byte 50 of a long block.
      stub_inv = 1'b0;
      for (int i = 0; i < 50; i++) send_byte(8'($urandom), i == 0, 1'b1);
      send_block(1'b1, 2);
      wait_idle();

      // Stray non-first byte in IDLE, then a normal block.
      send_byte(8'h3C, 1'b0, 1'b1);
      check("stray_err_pulse", err_pulse, 1);
      check("stray_busy", busy, 0);
      check("stray_in_ready", in_ready, 1);
      send_block(1'b0, 2);
      wait_idle();

      // Reset in the middle of DRAIN.
      send_block(1'b1, 2);
      base = pop_count;
      t = 0;
      while (pop_count - base < 100 && t < 5000) begin
         t++;
         @(posedge clock);
      end
      if (t >= 5000) check("mid_drain_timeout", pop_count - base, 100);
      #1;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      part.delete();
      @(negedge clock);
      check_reset_state("mid_reset");
      @(posedge clock);
      #1;
      send_block(1'b0, 2);
      wait_idle();

      // Randomised traffic: input gaps, random backpressure, random size.
      gaps_en  = 1'b1;
      out_mode = 2;
      for (int b = 0; b < 4; b++) begin
         stub_inv = 1'($urandom_range(0, 1));
         send_block(1'($urandom_range(0, 1)), 2);
         wait_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
